// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, seven-segment codes and elaboration-time helpers.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low abcd_efgp codes for digits 0..9 (index 0 is leftmost)
   localparam logic [0:9][7:0] SEG_TABLE = {
      8'b0000_0011,  // 0
      8'b1001_1111,  // 1
      8'b0010_0101,  // 2
      8'b0000_1101,  // 3
      8'b1001_1001,  // 4
      8'b0100_1001,  // 5
      8'b0100_0001,  // 6
      8'b0001_1011,  // 7
      8'b0000_0001,  // 8
      8'b0000_1001   // 9
   };

   // Segment pattern for one BCD digit; non-decimal codes show blank
   function automatic logic [7:0] seg_code(input logic [3:0] d);
      if (d < 4'd10) return SEG_TABLE[d];
      return SEG_BLANK;
   endfunction

   // 10**n, used to check that DIGITS can hold the largest input
   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   // Largest unsigned value representable in w bits
   function automatic longint unsigned max_bin(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit above 4 gets +3 before
// the shift so that doubling carries correctly into the next digit.
// Inputs are 0..9 in normal use, so the result never exceeds 12.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// start is accepted in IDLE or DONE; done pulses for one cycle when the
// result lands in bcd, which then holds until the next conversion ends.
// Optional feature: define BCD_SEG_EN to add the registered seg_7 output
// (active-low abcd_efgp per digit, leading zeros blanked, digit 0 never).
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_p,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_SEG_EN
   ,
   output logic [8*DIGITS-1:0]   seg_7
`endif
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
      $error("bin_to_bcd_seq: BIN_W must be in 4..32");
   end
   if (pow10(DIGITS) <= max_bin(BIN_W)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
   end

   state_t               state;
   logic [BIN_W-1:0]     sh;
   logic [4*DIGITS-1:0]  work;
   logic [4*DIGITS-1:0]  work_adj;
   logic [4*DIGITS-1:0]  work_nxt;
   logic [BIN_W-1:0]     sh_nxt;
   logic [CNT_W-1:0]     cnt;

   for (genvar k = 0; k < DIGITS; k++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (work[4*k +: 4]),
         .dout (work_adj[4*k +: 4])
      );
   end

   // {work, sh} shifted left by one after digit correction
   always_comb begin
      work_nxt = {work_adj[4*DIGITS-2:0], sh[BIN_W-1]};
      sh_nxt   = {sh[BIN_W-2:0], 1'b0};
   end

`ifdef BCD_SEG_EN
   logic [8*DIGITS-1:0] seg_nxt;
   logic                lead;

   // Segment decode of the final result with leading-zero blanking
   always_comb begin
      seg_nxt = '1;
      lead    = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (lead && (k != 0) && (work_nxt[4*k +: 4] == 4'd0)) begin
            seg_nxt[8*k +: 8] = SEG_BLANK;
         end else begin
            lead              = 1'b0;
            seg_nxt[8*k +: 8] = seg_code(work_nxt[4*k +: 4]);
         end
      end
   end
`endif

   // Control FSM, shift datapath and registered results
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         bcd   <= '0;
         sh    <= '0;
         work  <= '0;
         cnt   <= '0;
`ifdef BCD_SEG_EN
         seg_7 <= {DIGITS{SEG_BLANK}};
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sh    <= bin;
                  work  <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               sh   <= sh_nxt;
               work <= work_nxt;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  bcd   <= work_nxt;
`ifdef BCD_SEG_EN
                  seg_7 <= seg_nxt;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default 12-bit/4-digit instance
// plus an 8-bit/3-digit instance; seg_7 checks when BCD_SEG_EN is defined.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        reset_p;
   logic        start, start8;
   logic [11:0] bin;
   logic [7:0]  bin8;
   logic        busy, done, busy8, done8;
   logic [15:0] bcd;
   logic [11:0] bcd8;
`ifdef BCD_SEG_EN
   logic [31:0] seg;
   logic [23:0] seg8;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut (
      .clk     (clk),
      .reset_p (reset_p),
      .start   (start),
      .bin     (bin),
      .busy    (busy),
      .done    (done),
      .bcd     (bcd)
`ifdef BCD_SEG_EN
      ,
      .seg_7   (seg)
`endif
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
      .clk     (clk),
      .reset_p (reset_p),
      .start   (start8),
      .bin     (bin8),
      .busy    (busy8),
      .done    (done8),
      .bcd     (bcd8)
`ifdef BCD_SEG_EN
      ,
      .seg_7   (seg8)
`endif
   );

   // Reference: decimal digits by repeated division
   function automatic logic [31:0] model_bcd(input int unsigned v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_digit(input int d);
      case (d)
         0: return 8'h03;
         1: return 8'h9F;
         2: return 8'h25;
         3: return 8'h0D;
         4: return 8'h99;
         5: return 8'h49;
         6: return 8'h41;
         7: return 8'h1B;
         8: return 8'h01;
         9: return 8'h09;
         default: return 8'hFF;
      endcase
   endfunction

   // Reference: 4-digit display of v with leading zeros blanked
   function automatic logic [31:0] model_seg4(input int unsigned v);
      logic [31:0] r;
      int dig [4];
      int hi;
      hi = 0;
      for (int i = 0; i < 4; i++) begin
         dig[i] = int'(v % 10);
         v = v / 10;
         if (dig[i] != 0) hi = i;
      end
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = (i > hi) ? 8'hFF : seg_digit(dig[i]);
      return r;
   endfunction

   // Run one conversion on the 12-bit instance; bounded wait for done
   task automatic do_conv(input logic [11:0] val, output int cyc,
                          output logic [15:0] got, output logic bsy);
      bin   = val;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      got = bcd;
      bsy = busy;
   endtask

   task automatic test_reset();
      reset_p = 1'b1;
      start = 1'b0; start8 = 1'b0; bin = '0; bin8 = '0;
      @(posedge clk); #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0) begin
         n_fail++;
         $display("FAIL reset12 busy=%b done=%b bcd=%h expected 0/0/0000", busy, done, bcd);
      end
      n_tests++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 12'h0) begin
         n_fail++;
         $display("FAIL reset8 busy=%b done=%b bcd=%h expected 0/0/000", busy8, done8, bcd8);
      end
`ifdef BCD_SEG_EN
      n_tests++;
      if (seg !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL reset_seg got=%h expected ffffffff", seg);
      end
`endif
      reset_p = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero();
      int cyc; logic [15:0] got; logic bsy;
      do_conv(12'd0, cyc, got, bsy);
      n_tests++;
      if (cyc !== 13) begin
         n_fail++;
         $display("FAIL zero_latency got=%0d expected 13", cyc);
      end
      n_tests++;
      if (got !== 16'h0000 || bsy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_result bcd=%h busy=%b expected 0000/0", got, bsy);
      end
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse_width done=%b expected 0", done);
      end
   endtask

   task automatic test_values();
      int cyc; logic [15:0] got; logic bsy;
      int unsigned v;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) v = 4095;
         else if (i == 1) v = 1234;
         else v = $urandom_range(4095, 0);
         do_conv(12'(v), cyc, got, bsy);
         n_tests++;
         if (got !== model_bcd(v)[15:0] || cyc !== 13) begin
            n_fail++;
            $display("FAIL convert bin=%0d bcd=%h cyc=%0d expected %h/13", v, got, cyc, model_bcd(v)[15:0]);
         end
      end
   endtask

   task automatic test_bin_change();
      int c;
      bin = 12'd1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 1;
      while (done !== 1'b1 && c < 100) begin
         if (c == 3) bin = 12'd4321;
         @(posedge clk); #1;
         c++;
      end
      n_tests++;
      if (bcd !== 16'h1234 || c !== 13) begin
         n_fail++;
         $display("FAIL bin_change bcd=%h cyc=%0d expected 1234/13", bcd, c);
      end
   endtask

   task automatic test_back_to_back();
      int ndone, t1, t2;
      logic [15:0] b1, b2;
      ndone = 0; t1 = 0; t2 = 0; b1 = '0; b2 = '0;
      bin = 12'd999; start = 1'b1;
      @(posedge clk); #1;
      bin = 12'd7;
      for (int c = 1; c < 60; c++) begin
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin t1 = c; b1 = bcd; end
            if (ndone == 2) begin t2 = c; b2 = bcd; start = 1'b0; break; end
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      n_tests++;
      if (t1 !== 13 || t2 - t1 !== 13) begin
         n_fail++;
         $display("FAIL b2b_timing first=%0d second=%0d expected 13/26", t1, t2);
      end
      n_tests++;
      if (b1 !== 16'h0999 || b2 !== 16'h0007) begin
         n_fail++;
         $display("FAIL b2b_values got=%h,%h expected 0999,0007", b1, b2);
      end
      @(posedge clk); #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle busy=%b done=%b expected 0/0", busy, done);
      end
   endtask

   task automatic test_ignore_and_reset();
      int ndone, tdone;
      int unsigned v;
      logic [15:0] b;
      v = $urandom_range(4095, 1);
      ndone = 0; tdone = 0; b = '0;
      bin = 12'(v); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         start = (c == 5);
         if (done === 1'b1) begin ndone++; tdone = c; b = bcd; end
         @(posedge clk); #1;
      end
      start = 1'b0;
      n_tests++;
      if (ndone !== 1 || tdone !== 13 || b !== model_bcd(v)[15:0]) begin
         n_fail++;
         $display("FAIL ignore_start dones=%0d at=%0d bcd=%h expected 1/13/%h", ndone, tdone, b, model_bcd(v)[15:0]);
      end
      // abort a conversion with an asynchronous reset
      bin = 12'(v); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      reset_p = 1'b1;
      #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_abort busy=%b done=%b bcd=%h expected 0/0/0000", busy, done, bcd);
      end
      @(posedge clk); #1;
      reset_p = 1'b0;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1 || busy === 1'b1) ndone++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (ndone !== 0) begin
         n_fail++;
         $display("FAIL reset_no_done active_cycles=%0d expected 0", ndone);
      end
   endtask

   task automatic test_small();
      int c;
      int unsigned v;
      for (int i = 0; i < 4; i++) begin
         v = (i == 0) ? 255 : $urandom_range(255, 0);
         bin8 = 8'(v); start8 = 1'b1;
         @(posedge clk); #1;
         start8 = 1'b0;
         c = 1;
         while (done8 !== 1'b1 && c < 100) begin
            @(posedge clk); #1;
            c++;
         end
         n_tests++;
         if (c !== 9 || bcd8 !== model_bcd(v)[11:0]) begin
            n_fail++;
            $display("FAIL small bin=%0d bcd=%h cyc=%0d expected %h/9", v, bcd8, c, model_bcd(v)[11:0]);
         end
      end
   endtask

`ifdef BCD_SEG_EN
   task automatic test_seg();
      int cyc; logic [15:0] got; logic bsy;
      int unsigned v;
      do_conv(12'd47, cyc, got, bsy);
      n_tests++;
      if (seg !== {8'hFF, 8'hFF, 8'b1001_1001, 8'b0001_1011}) begin
         n_fail++;
         $display("FAIL seg_47 got=%h expected ffff991b", seg);
      end
      do_conv(12'd0, cyc, got, bsy);
      n_tests++;
      if (seg !== 32'hFFFF_FF03) begin
         n_fail++;
         $display("FAIL seg_0 got=%h expected ffffff03", seg);
      end
      for (int i = 0; i < 6; i++) begin
         v = $urandom_range(4095, 0);
         do_conv(12'(v), cyc, got, bsy);
         n_tests++;
         if (seg !== model_seg4(v)) begin
            n_fail++;
            $display("FAIL seg_rand bin=%0d got=%h expected %h", v, seg, model_seg4(v));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_zero();
      test_values();
      test_bin_change();
      test_back_to_back();
      test_ignore_and_reset();
      test_small();
`ifdef BCD_SEG_EN
      test_seg();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
